popcount_frame_accumulator: RTL and testbench

Downstream stage of the bit population counter. It consumes the per-word count and its valid strobe, then accumulates FRAME_LEN valid counts into one frame total and a frame maximum. Each result is presented on a ready/valid output held until accepted. The upstream counter has no backpressure, so an unaccepted result that gets replaced is flagged rather than stalled.

---
 rtl/popcount_pkg.sv | 14 +
 rtl/popcount_frame_accumulator_if.sv | 31 +++
 rtl/popcount_out_reg.sv | 44 ++++
 rtl/popcount_frame_accumulator.sv | 73 +++++++
 tb/tb_popcount_frame_accumulator.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// Shared sizing helpers for the popcount pipeline.
// The upstream counter and the frame accumulator both size their ports from these.
package popcount_pkg;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  // Widest total is every word fully set, so the sum must hold width*frame_len.
  function automatic int sum_width(input int width, input int frame_len);
    return $clog2(width * frame_len + 1);
  endfunction

endpackage

// File: rtl/popcount_frame_accumulator_if.sv
// Count input and frame-result ready/valid bundle for popcount_frame_accumulator.
// The slave modport is the accumulator side; master is the driver/consumer side.
interface popcount_frame_accumulator_if #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8
);
  import popcount_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int SUM_W = sum_width(WIDTH, FRAME_LEN);

  logic [CNT_W-1:0] cnt_i;
  logic             cnt_val_i;
  logic             frame_clr_i;
  logic [SUM_W-1:0] sum_o;
  logic [CNT_W-1:0] max_o;
  logic             sum_val_o;
  logic             sum_ready_i;
  logic             overrun_o;

  modport master (
    output cnt_i, cnt_val_i, frame_clr_i, sum_ready_i,
    input  sum_o, max_o, sum_val_o, overrun_o
  );

  modport slave (
    input  cnt_i, cnt_val_i, frame_clr_i, sum_ready_i,
    output sum_o, max_o, sum_val_o, overrun_o
  );

endinterface

// File: rtl/popcount_out_reg.sv
// Single-entry ready/valid holding register. A load while the held entry is
// still unaccepted overwrites it and raises a sticky overrun flag.
module popcount_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              overrun
);

  logic transfer;

  assign transfer = valid & ready;

  // Data only changes on load, so it holds after a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      data_out <= data_in;
      valid    <= 1'b1;
    end else if (transfer) begin
      valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (clr) begin
      overrun <= 1'b0;
    end else if (load && !transfer && valid) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/popcount_frame_accumulator.sv
// Accumulates FRAME_LEN valid popcounts into a frame total and frame maximum,
// presenting each result on a ready/valid output that flags overwrites.
module popcount_frame_accumulator
  import popcount_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8
) (
  input logic clk_i,
  input logic arst_i,
  popcount_frame_accumulator_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int SUM_W = sum_width(WIDTH, FRAME_LEN);
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [IDX_W-1:0] word_idx;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] max_q;
  logic [SUM_W-1:0] next_acc;
  logic [CNT_W-1:0] next_max;
  logic             first_word;
  logic             last_word;
  logic             accept;
  logic             complete;

  assign first_word = (word_idx == '0);
  assign last_word  = (word_idx == IDX_W'(FRAME_LEN - 1));
  assign accept     = bus.cnt_val_i & ~bus.frame_clr_i;
  assign complete   = accept & last_word;

  // The first word of a frame restarts the running values instead of adding to them.
  always_comb begin
    next_acc = SUM_W'(bus.cnt_i);
    next_max = bus.cnt_i;
    if (!first_word) begin
      next_acc = acc + SUM_W'(bus.cnt_i);
      next_max = (bus.cnt_i > max_q) ? bus.cnt_i : max_q;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      word_idx <= '0;
      acc      <= '0;
      max_q    <= '0;
    end else if (bus.frame_clr_i) begin
      word_idx <= '0;
      acc      <= '0;
      max_q    <= '0;
    end else if (bus.cnt_val_i) begin
      acc      <= next_acc;
      max_q    <= next_max;
      word_idx <= last_word ? '0 : word_idx + 1'b1;
    end
  end

  popcount_out_reg #(
    .DATA_W(SUM_W + CNT_W)
  ) u_out_reg (
    .clk     (clk_i),
    .rst     (arst_i),
    .load    (complete),
    .data_in ({next_max, next_acc}),
    .ready   (bus.sum_ready_i),
    .clr     (bus.frame_clr_i),
    .data_out({bus.max_o, bus.sum_o}),
    .valid   (bus.sum_val_o),
    .overrun (bus.overrun_o)
  );

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Scoreboard bench for popcount_frame_accumulator (WIDTH=16, FRAME_LEN=4):
// stimulus queues hand-computed results, a negedge monitor checks each transfer.
module tb_popcount_frame_accumulator;

  localparam int WIDTH     = 16;
  localparam int FRAME_LEN = 4;

  typedef struct {
    int sum;
    int max;
    int cyc;
  } expect_t;

  logic    clk;
  logic    arst;
  int      checks;
  int      errors;
  int      cycle;
  expect_t exp_q[$];

  popcount_frame_accumulator_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) bus ();

  popcount_frame_accumulator #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Every accepted result must match the oldest queued expectation, in the expected cycle.
  always @(negedge clk) begin
    if (!arst && bus.sum_val_o && bus.sum_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_result actual sum=%0d max=%0d cycle=%0d required none",
                 bus.sum_o, bus.max_o, cycle);
      end else begin
        expect_t e;
        e = exp_q.pop_front();
        if (int'(bus.sum_o) != e.sum || int'(bus.max_o) != e.max || cycle != e.cyc) begin
          errors++;
          $display("[TB] FAIL result actual sum=%0d max=%0d cycle=%0d required sum=%0d max=%0d cycle=%0d",
                   bus.sum_o, bus.max_o, cycle, e.sum, e.max, e.cyc);
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input int cnt, input bit clr);
    bus.cnt_i       = 5'(cnt);
    bus.cnt_val_i   = 1'b1;
    bus.frame_clr_i = clr;
    @(posedge clk);
    #1;
    bus.cnt_val_i   = 1'b0;
    bus.frame_clr_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call right after the last word of a frame returns: the result transfers this cycle.
  task automatic push_expect(input int sum, input int max);
    expect_t e;
    e.sum = sum;
    e.max = max;
    e.cyc = cycle;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_sum"},     int'(bus.sum_o),     0);
    check_output({tag, "_max"},     int'(bus.max_o),     0);
    check_output({tag, "_valid"},   int'(bus.sum_val_o), 0);
    check_output({tag, "_overrun"}, int'(bus.overrun_o), 0);
  endtask

  initial begin
    int gaps[4];
    int vals[4];
    checks = 0;
    errors = 0;
    cycle  = 0;
    arst            = 1'b1;
    bus.cnt_i       = '0;
    bus.cnt_val_i   = 1'b0;
    bus.frame_clr_i = 1'b0;
    bus.sum_ready_i = 1'b1;
    idle(3);
    check_all_zero("reset");
    arst = 1'b0;
    idle(1);

    // Back-to-back frame 3,16,0,7.
    vals = '{3, 16, 0, 7};
    foreach (vals[i]) apply_stimulus(vals[i], 1'b0);
    push_expect(26, 16);
    idle(1);
    check_output("one_cycle_valid", int'(bus.sum_val_o), 0);
    check_output("hold_sum_after_transfer", int'(bus.sum_o), 26);
    idle(1);

    // Same frame with idle gaps between words.
    gaps = '{1, 3, 0, 2};
    foreach (vals[i]) begin
      apply_stimulus(vals[i], 1'b0);
      if (i < 3) idle(gaps[i]);
    end
    push_expect(26, 16);
    idle(2);

    // No acceptance: frame A held, then overwritten by frame B.
    bus.sum_ready_i = 1'b0;
    repeat (4) apply_stimulus(1, 1'b0);
    check_output("held_a_valid", int'(bus.sum_val_o), 1);
    check_output("held_a_sum", int'(bus.sum_o), 4);
    check_output("held_a_overrun", int'(bus.overrun_o), 0);
    idle(2);
    check_output("held_a_sum_stable", int'(bus.sum_o), 4);
    repeat (4) apply_stimulus(2, 1'b0);
    check_output("replaced_sum", int'(bus.sum_o), 8);
    check_output("replaced_overrun", int'(bus.overrun_o), 1);
    bus.sum_ready_i = 1'b1;
    push_expect(8, 2);
    idle(1);
    check_output("after_accept_valid", int'(bus.sum_val_o), 0);
    check_output("after_accept_overrun", int'(bus.overrun_o), 1);
    idle(1);

    // Clear drops the partial frame and its own word, and clears overrun.
    apply_stimulus(5, 1'b0);
    apply_stimulus(5, 1'b0);
    apply_stimulus(9, 1'b1);
    check_output("clr_overrun", int'(bus.overrun_o), 0);
    for (int c = 1; c <= 4; c++) apply_stimulus(c, 1'b0);
    push_expect(10, 4);
    idle(2);

    // Continuous full-rate all-16 words, three frames.
    for (int w = 1; w <= 12; w++) begin
      apply_stimulus(16, 1'b0);
      if (w % 4 == 0) push_expect(64, 16);
    end
    check_output("stream_overrun", int'(bus.overrun_o), 0);
    idle(2);

    // Reset with a pending result and a partial frame in progress.
    bus.sum_ready_i = 1'b0;
    for (int c = 1; c <= 4; c++) apply_stimulus(c, 1'b0);
    apply_stimulus(5, 1'b0);
    apply_stimulus(5, 1'b0);
    check_output("pending_before_reset", int'(bus.sum_val_o), 1);
    arst = 1'b1;
    #1;
    check_all_zero("async_reset");
    idle(1);
    arst = 1'b0;
    bus.sum_ready_i = 1'b1;
    vals = '{2, 3, 4, 5};
    foreach (vals[i]) apply_stimulus(vals[i], 1'b0);
    push_expect(14, 5);
    idle(3);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
